// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the two-input gate truth-table checker.
package gate_tt_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] NAND_TT = 4'b0111;

  // Saturation is unnecessary: at most four vectors can mismatch per sweep.
  function automatic logic [2:0] err_inc(input logic [2:0] cnt, input logic mis);
    return cnt + {2'b00, mis};
  endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Loadable down-counter; o_expire marks the last cycle of a settle window.
module gate_settle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != {W{1'b0}})) begin
      r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expire = i_dec && (r_count == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/gate_tt_checker.sv
// Sweeps {a,b} through 00,01,10,11, samples the gate output after a settle
// window and reports mismatches against the expected truth table.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  GATE_FN       = NOR_TT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_err_vec,
  output logic       err_valid
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES);

  state_t     r_state;
  logic [1:0] r_vec;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err_count;
  logic [1:0] r_first_err_vec;
  logic       r_err_valid;

  logic       w_accept;
  logic       w_next_vec;
  logic       w_load;
  logic       w_dec;
  logic       w_expire;
  logic       w_exp;
  logic       w_mismatch;
  logic [2:0] w_cnt_next;

  assign w_accept   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  assign w_next_vec = (r_state == ST_SAMPLE) && (r_vec != 2'd3);
  assign w_load     = w_accept || w_next_vec;
  assign w_dec      = (r_state == ST_SETTLE);
  assign w_exp      = GATE_FN[r_vec];
  // Case equality so an x or z returned by the gate counts as a mismatch.
  assign w_mismatch = !(y === w_exp);
  assign w_cnt_next = err_inc(r_err_count, w_mismatch);

  gate_settle_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_expire   (w_expire)
  );

  // Sweep sequencer; the vector counter is also the registered {a,b} drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_vec           <= 2'd0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_err_count     <= 3'd0;
      r_first_err_vec <= 2'd0;
      r_err_valid     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state         <= ST_SETTLE;
            r_vec           <= 2'd0;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_count     <= 3'd0;
            r_first_err_vec <= 2'd0;
            r_err_valid     <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (w_expire) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          r_err_count <= w_cnt_next;
          if (w_mismatch && !r_err_valid) begin
            r_err_valid     <= 1'b1;
            r_first_err_vec <= r_vec;
          end
          if (r_vec == 2'd3) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_cnt_next == 3'd0);
          end else begin
            r_state <= ST_SETTLE;
            r_vec   <= r_vec + 2'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a             = r_vec[1];
  assign b             = r_vec[0];
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err_count;
  assign first_err_vec = r_first_err_vec;
  assign err_valid     = r_err_valid;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: two instances (settle 1 and settle 3) driving a
// table-defined gate model, checked against an arithmetic sweep model.
module tb_gate_tt_checker;
  import gate_tt_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start0 = 1'b0, start3 = 1'b0;
  logic [3:0] tbl0 = NOR_TT, tbl3 = NOR_TT;
  logic       a0, b0, y0, busy0, done0, pass0, ev0;
  logic       a3, b3, y3, busy3, done3, pass3, ev3;
  logic [2:0] ec0, ec3;
  logic [1:0] fe0, fe3;

  assign y0 = tbl0[{a0, b0}];
  assign y3 = tbl3[{a3, b3}];

  int n_vec = 0;
  int n_err = 0;

  gate_tt_checker u_dut (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0),
    .first_err_vec(fe0), .err_valid(ev0)
  );

  gate_tt_checker #(.SETTLE_CYCLES(3), .GATE_FN(NOR_TT)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(ec3),
    .first_err_vec(fe3), .err_valid(ev3)
  );

  typedef struct packed {
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] ec;
    logic [1:0] fe;
    logic       ev;
  } obs_t;

  function automatic obs_t sample(input int sel);
    if (sel == 3) return {a3, b3, busy3, done3, pass3, ec3, fe3, ev3};
    else          return {a0, b0, busy0, done0, pass0, ec0, fe0, ev0};
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 3) start3 = v;
    else          start0 = v;
  endtask

  // Full sweep against the model: vector k/(S+1) on cycle k, done on 4*(S+1).
  task automatic run_sweep(input int sel, input logic [3:0] tbl, input int busy_k);
    int         s, total, exp_cnt, exp_first, vi;
    logic [1:0] exp_vec;
    obs_t       o;
    s         = (sel == 3) ? 3 : 1;
    total     = 4 * (s + 1);
    exp_cnt   = 0;
    exp_first = -1;
    for (int i = 0; i < 4; i++) begin
      if (tbl[i] != NOR_TT[i]) begin
        exp_cnt++;
        if (exp_first < 0) exp_first = i;
      end
    end
    if (sel == 3) tbl3 = tbl;
    else          tbl0 = tbl;
    set_start(sel, 1'b1);
    @(posedge clk); @(negedge clk);
    set_start(sel, 1'b0);
    for (int k = 0; k <= total; k++) begin
      if (k > 0) begin
        if (k == busy_k) set_start(sel, 1'b1);
        @(posedge clk); @(negedge clk);
        set_start(sel, 1'b0);
      end
      o = sample(sel);
      vi = k / (s + 1);
      if (vi > 3) vi = 3;
      exp_vec = 2'(vi);
      n_vec++;
      if ({o.a, o.b, o.busy, o.done} !== {exp_vec, (k < total), (k == total)}) begin
        n_err++;
        $display("FAIL seq sel=%0d k=%0d: got ab=%b%b busy=%b done=%b, want ab=%b busy=%b done=%b",
                 sel, k, o.a, o.b, o.busy, o.done, exp_vec, (k < total), (k == total));
      end
      if (k == 0) begin
        n_vec++;
        if ({o.ec, o.ev, o.done} !== 5'b0) begin
          n_err++;
          $display("FAIL clear sel=%0d: got ec=%0d ev=%b done=%b, want 0 0 0", sel, o.ec, o.ev, o.done);
        end
      end
    end
    for (int j = 0; j < 2; j++) begin
      o = sample(sel);
      n_vec++;
      if ({o.pass, o.ec, o.ev, o.a, o.b, o.done} !==
          {(exp_cnt == 0), 3'(exp_cnt), (exp_cnt != 0), 2'b11, 1'b1}) begin
        n_err++;
        $display("FAIL result sel=%0d tbl=%b: got pass=%b ec=%0d ev=%b ab=%b%b, want pass=%b ec=%0d ev=%b ab=11",
                 sel, tbl, o.pass, o.ec, o.ev, o.a, o.b, (exp_cnt == 0), exp_cnt, (exp_cnt != 0));
      end
      if (exp_cnt != 0) begin
        n_vec++;
        if (o.fe !== 2'(exp_first)) begin
          n_err++;
          $display("FAIL first_err sel=%0d tbl=%b: got %b, want %0d", sel, tbl, o.fe, exp_first);
        end
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      o = sample(i * 3);
      n_vec++;
      if (o !== '0) begin
        n_err++;
        $display("FAIL reset sel=%0d: got %b, want all zero", i * 3, o);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_nor_pass();     run_sweep(0, NOR_TT, -1); endtask
  task automatic test_stuck_low();    run_sweep(0, 4'b0000, -1); endtask
  task automatic test_or_gate();      run_sweep(0, OR_TT, -1); endtask
  task automatic test_settle3();      run_sweep(3, NOR_TT, -1); run_sweep(3, AND_TT, -1); endtask

  task automatic test_back_to_back();
    run_sweep(0, NAND_TT, 3);
    run_sweep(0, NOR_TT, 7);
    run_sweep(3, OR_TT, 9);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    set_start(0, 1'b1);
    @(posedge clk); @(negedge clk);
    set_start(0, 1'b0);
    repeat (4) @(negedge clk);
    o = sample(0);
    n_vec++;
    if ({o.a, o.b, o.busy} !== 3'b101) begin
      n_err++;
      $display("FAIL pre_reset: got ab=%b%b busy=%b, want ab=10 busy=1", o.a, o.b, o.busy);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    o = sample(0);
    n_vec++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got %b, want all zero", o);
    end
    repeat (8) @(negedge clk);
    o = sample(0);
    n_vec++;
    if ({o.busy, o.done} !== 2'b00) begin
      n_err++;
      $display("FAIL no_done_after_abort: got busy=%b done=%b, want 0 0", o.busy, o.done);
    end
    run_sweep(0, NOR_TT, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int         sel;
      logic [3:0] tbl;
      sel = ($urandom_range(0, 1) == 0) ? 0 : 3;
      tbl = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_sweep(sel, tbl, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 7)));
    end
  endtask

  initial begin
    test_reset();
    test_nor_pass();
    test_stuck_low();
    test_or_gate();
    test_settle3();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gate_tt_checker.md
GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, the cycles each input vector is held before y is sampled (legal range 1..15).
REQ-002 SHALL have parameter GATE_FN, default 4'b0001, the expected truth table, where bit index {a,b} gives the expected y (default = NOR).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to run a full truth-table sweep.
REQ-006 SHALL have port a  output  1  drive to the gate-under-test input a.
REQ-007 SHALL have port b  output  1  drive to the gate-under-test input b.
REQ-008 SHALL have port y  input  1  output returned from the gate under test.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  high from sweep completion until the next accepted start or reset.
REQ-011 SHALL have port pass  output  1  valid when done is high; 1 iff err_count == 0.
REQ-012 SHALL have port err_count  output  3  number of mismatching vectors in the last sweep, 0..4.
REQ-013 SHALL have port first_err_vec  output  2  the {a,b} value of the first mismatch; valid when err_valid is high.
REQ-014 SHALL have port err_valid  output  1  high once any mismatch has been recorded in the current or last sweep.

Function
REQ-015 SHALL implement the FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 SHALL, in IDLE or DONE with start=1, clear err_count, err_valid, first_err_vec, done and the vector counter, drive {a,b}=00, load the settle counter with SETTLE_CYCLES and go to SETTLE.
REQ-017 SHALL hold a and b stable in SETTLE, decrement the settle counter each cycle, and go to SAMPLE after exactly SETTLE_CYCLES cycles.
REQ-018 SHALL compare y against GATE_FN[{a,b}] at the clock edge that ends SAMPLE, with any mismatch (an x or z on y counts as a mismatch in simulation) incrementing err_count.
REQ-019 SHALL, on the first mismatch of a sweep only, set err_valid=1 and capture first_err_vec={a,b}; later mismatches SHALL NOT overwrite them.
REQ-020 SHALL, leaving SAMPLE with vector < 3, increment the vector, drive the next {a,b}, reload the settle counter and return to SETTLE; vector order is 00, 01, 10, 11.
REQ-021 SHALL, leaving SAMPLE with vector == 3, go to DONE with done=1, pass=(final err_count==0), and a,b held at 11.
REQ-022 SHALL assert done exactly 4*(SETTLE_CYCLES+1) clock edges after the edge that accepts start (8 edges at the default).
REQ-023 SHALL drive busy=1 exactly in SETTLE and SAMPLE.
REQ-024 SHALL ignore start while busy, with no restart and no effect on counters.
REQ-025 SHALL let the mismatch count at the final SAMPLE edge take effect in the same cycle done rises, so pass reflects all four vectors.
REQ-026 SHALL hold err_count, pass, err_valid and first_err_vec stable in DONE until the next accepted start.

Reset
REQ-027 SHALL, with rst=1 at a rising edge, force state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, err_valid=0, first_err_vec=00 and the counters to 0.
REQ-028 SHALL let rst take priority over start; a reset mid-sweep SHALL abort the sweep with no done pulse.

Structure
REQ-029 SHALL place the FSM state enum, the state width, and the truth-table constants NOR_TT=4'b0001, OR_TT=4'b1110, AND_TT=4'b1000 and NAND_TT=4'b0111 in the shared package gate_tt_pkg.
REQ-030 SHALL implement the settle timing as one sub-module, gate_settle_timer (load, count-down, expire pulse), instantiated once.

Verification
REQ-031 SHALL cover: nor_gate connected, default parameters, start pulse -> done after 8 edges, pass=1, err_count=0, err_valid=0, {a,b} sequence 00,01,10,11.
REQ-032 SHALL cover: y tied to 0, GATE_FN=NOR_TT -> err_count=1, err_valid=1, first_err_vec=00, pass=0.
REQ-033 SHALL cover: or gate connected with GATE_FN=NOR_TT -> err_count=4, first_err_vec=00, pass=0.
REQ-034 SHALL cover: SETTLE_CYCLES=3 -> each vector held 3 cycles and sampled on the 4th, done after 16 edges.
REQ-035 SHALL cover: start repeated while busy -> ignored, done still at edge 8; start again in DONE -> error fields cleared and a new sweep begins.
REQ-036 SHALL cover: rst asserted during vector 10 -> next cycle all outputs at reset values, no done, and a subsequent start completes normally.
